// File: rtl/motor_dps_spi_tx.sv
// Write-only SPI master for the GoPiGo3 motor board.
// Each left/right dps command update is sent as two 5-byte SET_MOTOR_DPS
// frames, left frame first. An unchanged pair is re-sent after a refresh
// interval so the board never times out.
module motor_dps_spi_tx #(
  parameter int          nb_dps_motor     = 16,
  parameter logic [7:0]  c_spi_addr       = 8'h08,
  parameter logic [7:0]  c_msg_dps        = 8'h0C,
  parameter int          c_sclk_div       = 25,
  parameter int          c_cs_gap         = 50,
  parameter int          c_refresh_cycles = 2500000,
  parameter int          nb_refresh       = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [nb_dps_motor-1:0] motor_dps_left_i,
  input  logic [nb_dps_motor-1:0] motor_dps_rght_i,
  output logic                    spi_cs_n,
  output logic                    spi_sclk,
  output logic                    spi_mosi,
  output logic                    busy,
  output logic                    pair_done
);

  localparam int CNT_MAX = (c_sclk_div > c_cs_gap) ? c_sclk_div : c_cs_gap;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(c_sclk_div - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(c_cs_gap - 1);
  localparam logic [nb_refresh-1:0] REF_LAST = nb_refresh'(c_refresh_cycles - 1);
  localparam logic [6:0] HALF_LAST = 7'd79;  // 80 sclk half-periods per frame

  typedef enum logic [2:0] {S_IDLE, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_GAP} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [6:0]              half_q, half_d;
  logic [39:0]             sr_q, sr_d;      // sr_q[39] is the bit on the wire
  logic                    sclk_q, sclk_d;
  logic                    cs_n_q, cs_n_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    sel_q, sel_d;    // 0: left frame, 1: right frame
  logic [nb_dps_motor-1:0] snap_l_q, snap_l_d, snap_r_q, snap_r_d;
  logic [nb_dps_motor-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
  logic [nb_refresh-1:0]   ref_q, ref_d;
  logic                    force_q, force_d;
  logic [nb_dps_motor-1:0] eff_l, eff_r;
  logic                    pending;

  function automatic logic [39:0] mk_frame(input logic right, input logic [nb_dps_motor-1:0] dps);
    return {c_spi_addr, c_msg_dps, (right ? 8'h02 : 8'h01), 16'(dps)};
  endfunction

  // Effective command and send request, evaluated every cycle.
  always_comb begin
    eff_l   = enable ? motor_dps_left_i : '0;
    eff_r   = enable ? motor_dps_rght_i : '0;
    pending = force_q | (eff_l != last_l_q) | (eff_r != last_r_q) | (ref_q == REF_LAST);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      half_q   <= '0;
      sr_q     <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sel_q    <= 1'b0;
      snap_l_q <= '0;
      snap_r_q <= '0;
      last_l_q <= '0;
      last_r_q <= '0;
      ref_q    <= '0;
      force_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      sr_q     <= sr_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sel_q    <= sel_d;
      snap_l_q <= snap_l_d;
      snap_r_q <= snap_r_d;
      last_l_q <= last_l_d;
      last_r_q <= last_r_d;
      ref_q    <= ref_d;
      force_q  <= force_d;
    end
  end

  // Frame sequencing: next state and register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    half_d   = half_q;
    sr_d     = sr_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sel_d    = sel_q;
    snap_l_d = snap_l_q;
    snap_r_d = snap_r_q;
    last_l_d = last_l_q;
    last_r_d = last_r_q;
    ref_d    = ref_q;
    force_d  = force_q;
    case (state_q)
      S_IDLE: begin
        if (ref_q != REF_LAST) ref_d = ref_q + 1'b1;
        if (pending) begin
          // Both commands are captured together so the pair is coherent.
          snap_l_d = eff_l;
          snap_r_d = eff_r;
          sel_d    = 1'b0;
          busy_d   = 1'b1;
          cs_n_d   = 1'b0;
          sr_d     = mk_frame(1'b0, eff_l);
          force_d  = 1'b0;
          ref_d    = '0;
          cnt_d    = '0;
          state_d  = S_CS_SETUP;
        end
      end
      S_CS_SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          half_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          half_d = half_q + 1'b1;
          // Data advances only on falling edges; nothing after the 40th bit.
          if (sclk_q) begin
            if (half_q == HALF_LAST) state_d = S_CS_HOLD;
            else                     sr_d    = {sr_q[38:0], 1'b0};
          end
        end
      end
      S_CS_HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          sr_d    = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (!sel_q) begin
            sel_d   = 1'b1;
            cs_n_d  = 1'b0;
            sr_d    = mk_frame(1'b1, snap_r_q);
            state_d = S_CS_SETUP;
          end else begin
            last_l_d = snap_l_q;
            last_r_d = snap_r_q;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign spi_cs_n  = cs_n_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = sr_q[39];
  assign busy      = busy_q;
  assign pair_done = done_q;

endmodule

// File: tb/tb_motor_dps_spi_tx.sv
// Bench for motor_dps_spi_tx: a passive SPI monitor decodes frames from the
// pins and a small command model predicts the bytes each pair must carry.
module tb_motor_dps_spi_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] left_i = '0, rght_i = '0;
  logic        spi_cs_n, spi_sclk, spi_mosi, busy, pair_done;

  int vec = 0, errs = 0;

  motor_dps_spi_tx #(
    .nb_dps_motor(16), .c_spi_addr(8'h08), .c_msg_dps(8'h0C),
    .c_sclk_div(2), .c_cs_gap(4), .c_refresh_cycles(100), .nb_refresh(7)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .motor_dps_left_i(left_i), .motor_dps_rght_i(rght_i),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .busy(busy), .pair_done(pair_done)
  );

  always #5 clk = ~clk;

  // ---------------- pin monitor ----------------
  logic [39:0] fr_q[$];
  int          rc_q[$], len_q[$];
  logic [39:0] cur;
  int nrise = 0, cslen = 0, sclk_bad = 0, pulse_bad = 0, done_cnt = 0;
  int bhi = 0, idle_n = 0, last_idle = -1, last_span = -1;
  logic p_cs = 1'b1, p_sclk = 1'b0, p_busy = 1'b0, p_done = 1'b0;

  // Decode frames, measure pair span and idle time between pairs.
  always @(negedge clk) begin
    if (!spi_cs_n) begin
      if (p_cs) begin cur = '0; nrise = 0; cslen = 0; end
      cslen++;
      if (spi_sclk && !p_sclk) begin cur = {cur[38:0], spi_mosi}; nrise++; end
    end else begin
      if (spi_sclk) sclk_bad++;
      if (!p_cs) begin fr_q.push_back(cur); rc_q.push_back(nrise); len_q.push_back(cslen); end
    end
    if (busy) begin
      if (!p_busy) begin last_idle = idle_n; bhi = 0; end
      bhi++;
    end else idle_n = p_busy ? 1 : idle_n + 1;
    if (pair_done) begin
      last_span = bhi + 1;   // busy cycles plus the pair_done cycle
      done_cnt++;
      if (p_done) pulse_bad++;
    end
    p_cs = spi_cs_n; p_sclk = spi_sclk; p_busy = busy; p_done = pair_done;
  end

  // ---------------- reference model ----------------
  function automatic logic [39:0] exp_frame(input bit right, input logic [15:0] dps);
    logic [7:0] mask;
    mask = right ? 8'h02 : 8'h01;
    return {8'h08, 8'h0C, mask, dps};
  endfunction

  function automatic logic [15:0] eff(input logic en, input logic [15:0] v);
    return en ? v : 16'h0000;
  endfunction

  // ---------------- helpers (no checking) ----------------
  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (pair_done) ok = 1;
    end
    #1;
  endtask

  task automatic pop_pair(output logic [39:0] fl, output logic [39:0] fr, output int rl, output int rr);
    fl = 'x; fr = 'x; rl = -1; rr = -1;
    if (fr_q.size() >= 2) begin
      fl = fr_q.pop_front(); fr = fr_q.pop_front();
      rl = rc_q.pop_front(); rr = rc_q.pop_front();
    end
  endtask

  task automatic flush();
    fr_q.delete(); rc_q.delete(); len_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit ok; logic [39:0] fl, fr; int rl, rr, ln;
    rst = 1; enable = 1; left_i = 0; rght_i = 0;
    repeat (3) @(negedge clk);
    vec++; if ({spi_cs_n, spi_sclk, spi_mosi, busy, pair_done} !== 5'b10000) begin
      errs++; $display("FAIL reset_outputs got %b exp 10000", {spi_cs_n, spi_sclk, spi_mosi, busy, pair_done}); end
    rst = 0;
    @(negedge clk);
    vec++; if ({busy, spi_cs_n} !== 2'b10) begin
      errs++; $display("FAIL forced_start got busy/cs_n %b exp 10", {busy, spi_cs_n}); end
    wait_done(ok);
    vec++; if (!ok) begin errs++; $display("FAIL reset_pair_timeout got none exp pair_done"); end
    vec++; if (last_span !== 337) begin errs++; $display("FAIL pair_span got %0d exp 337", last_span); end
    ln = (len_q.size() > 0) ? len_q[0] : -1;
    vec++; if (ln !== 164) begin errs++; $display("FAIL cs_low_len got %0d exp 164", ln); end
    pop_pair(fl, fr, rl, rr);
    vec++; if (fl !== exp_frame(0, 16'h0000)) begin errs++; $display("FAIL reset_left_frame got %h exp %h", fl, exp_frame(0, 16'h0000)); end
    vec++; if (fr !== exp_frame(1, 16'h0000)) begin errs++; $display("FAIL reset_right_frame got %h exp %h", fr, exp_frame(1, 16'h0000)); end
  endtask

  task automatic test_frames();
    bit ok; logic [39:0] fl, fr; int rl, rr;
    flush(); sclk_bad = 0;
    left_i = 16'd600; rght_i = -16'sd250;
    wait_done(ok);
    vec++; if (!ok) begin errs++; $display("FAIL frames_timeout got none exp pair_done"); end
    pop_pair(fl, fr, rl, rr);
    vec++; if (fl !== 40'h080C010258) begin errs++; $display("FAIL frame_left got %h exp 080c010258", fl); end
    vec++; if (fr !== 40'h080C02FF06) begin errs++; $display("FAIL frame_right got %h exp 080c02ff06", fr); end
    vec++; if (rl !== 40 || rr !== 40) begin errs++; $display("FAIL rise_count got %0d/%0d exp 40/40", rl, rr); end
    vec++; if (sclk_bad !== 0) begin errs++; $display("FAIL sclk_idle got %0d high cycles exp 0", sclk_bad); end
  endtask

  task automatic test_midchange();
    bit ok; logic [39:0] fl, fr; int rl, rr;
    flush();
    rght_i = 16'd100;                   // triggers a pair carrying L=600
    repeat (40) @(negedge clk);
    left_i = 16'd550;                   // lands mid left frame
    wait_done(ok);
    pop_pair(fl, fr, rl, rr);
    vec++; if (!ok || fl !== exp_frame(0, 16'd600) || fr !== exp_frame(1, 16'd100)) begin
      errs++; $display("FAIL midchange_inflight got %h/%h exp %h/%h", fl, fr, exp_frame(0, 16'd600), exp_frame(1, 16'd100)); end
    wait_done(ok);
    vec++; if (last_idle !== 1) begin errs++; $display("FAIL midchange_restart got %0d idle cycles exp 1", last_idle); end
    pop_pair(fl, fr, rl, rr);
    vec++; if (!ok || fl !== exp_frame(0, 16'h0226)) begin errs++; $display("FAIL midchange_next got %h exp %h", fl, exp_frame(0, 16'h0226)); end
  endtask

  task automatic test_refresh();
    bit ok; logic [39:0] fl, fr; int rl, rr;
    for (int k = 0; k < 2; k++) begin
      flush();
      wait_done(ok);
      vec++; if (!ok || last_idle !== 100) begin errs++; $display("FAIL refresh_interval got %0d exp 100", last_idle); end
      pop_pair(fl, fr, rl, rr);
      vec++; if (fl !== exp_frame(0, 16'd550) || fr !== exp_frame(1, 16'd100)) begin
        errs++; $display("FAIL refresh_data got %h/%h exp %h/%h", fl, fr, exp_frame(0, 16'd550), exp_frame(1, 16'd100)); end
    end
  endtask

  task automatic test_enable();
    bit ok; logic [39:0] fl, fr; int rl, rr;
    flush();
    left_i = 16'd600; rght_i = 16'd600; enable = 0;
    wait_done(ok);
    pop_pair(fl, fr, rl, rr);
    vec++; if (!ok || fl !== exp_frame(0, 16'h0) || fr !== exp_frame(1, 16'h0)) begin
      errs++; $display("FAIL enable_off got %h/%h exp zero dps", fl, fr); end
    flush();
    enable = 1;
    wait_done(ok);
    pop_pair(fl, fr, rl, rr);
    vec++; if (!ok || fl !== exp_frame(0, 16'h0258) || fr !== exp_frame(1, 16'h0258)) begin
      errs++; $display("FAIL enable_on got %h/%h exp 0258/0258", fl, fr); end
  endtask

  task automatic test_random();
    bit ok; logic [39:0] fl, fr; int rl, rr;
    logic [15:0] l, r; logic en;
    for (int k = 0; k < 8; k++) begin
      flush();
      l = 16'($urandom); r = 16'($urandom); en = ($urandom_range(0, 3) != 0);
      left_i = l; rght_i = r; enable = en;
      wait_done(ok);
      pop_pair(fl, fr, rl, rr);
      vec++; if (!ok || fl !== exp_frame(0, eff(en, l)) || fr !== exp_frame(1, eff(en, r)) || rl !== 40 || rr !== 40) begin
        errs++; $display("FAIL random_%0d got %h/%h rises %0d/%0d exp %h/%h", k, fl, fr, rl, rr,
                         exp_frame(0, eff(en, l)), exp_frame(1, eff(en, r))); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [39:0] fl, fr; int rl, rr, dc;
    enable = 1; left_i = 16'd1234; rght_i = 16'hFEDC;
    repeat (30) @(negedge clk);         // inside SHIFT of the left frame
    dc = done_cnt;
    rst = 1;
    @(negedge clk);
    #1;
    vec++; if ({spi_cs_n, spi_sclk, busy, pair_done} !== 4'b1000) begin
      errs++; $display("FAIL reset_abort got %b exp 1000", {spi_cs_n, spi_sclk, busy, pair_done}); end
    flush();
    rst = 0;
    @(negedge clk);
    vec++; if (busy !== 1'b1 || done_cnt !== dc) begin
      errs++; $display("FAIL reset_restart got busy %b dones %0d exp busy 1 dones %0d", busy, done_cnt, dc); end
    wait_done(ok);
    pop_pair(fl, fr, rl, rr);
    vec++; if (!ok || done_cnt !== dc + 1 || fl !== exp_frame(0, 16'd1234) || fr !== exp_frame(1, 16'hFEDC)) begin
      errs++; $display("FAIL reset_forced_pair got %h/%h dones %0d exp %h/%h dones %0d", fl, fr, done_cnt,
                       exp_frame(0, 16'd1234), exp_frame(1, 16'hFEDC), dc + 1); end
    vec++; if (pulse_bad !== 0) begin errs++; $display("FAIL done_pulse_width got %0d long pulses exp 0", pulse_bad); end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_midchange();
    test_refresh();
    test_enable();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
